dma_csr_regfile: RTL
====================

// Module: dma_csr_regfile
// PURPOSE
//  Responder side of the DMA CSR request interface (csr_req_t in, csr_resp_t out), mapped at VENUSDMA_CTRLREG_OFFSET.
//  Holds the descriptor, config and status registers, and launches transfers into the DMA FSM/streamer.
//  Captures the first completion or error, and raises an interrupt. Sits between the SoC CSR bridge and the DMA core.
// PARAMETERS
//  BASE_ADDR    32'h1ffe_0000  CSR window base; addr[31:6] must match BASE_ADDR[31:6] or the access is ignored
//  BURST_EN_RST `DMA_MAX_BURST_EN  reset value of CFG.burst_en
// PORTS
//  clk_i         in   1    single clock
//  rst_ni        in   1    reset, asynchronous, active-low
//  csr_req_i     in   csr_req_t   wr_en/waddr/wdata (full 32b write, no strobe), rd_en
//  csr_resp_o    out  csr_resp_t  512b snapshot of the whole window
//  csr_rvalid_o  out  1    one-cycle pulse: csr_resp_o updated
//  dma_desc_o    out  s_dma_desc_t  src/num_bytes/dst to streamer
//  dma_go_o      out  1    one-cycle start pulse to the DMA FSM
//  burst_en_o    out  1    CFG.burst_en
//  dma_done_i    in   1    one-cycle pulse from the DMA FSM: transfer finished
//  dma_error_i   in   s_dma_error_t  valid/src/addr from AXI IF / streamer
//  dma_status_o  out  s_dma_status_t  {error,done,active}
//  irq_o         out  1    level interrupt = CFG.irq_en & (done | error)
// BEHAVIOUR
//  Register map (waddr[5:0]); each register occupies a 64b slot with [31:0] valid and [63:32] reading 0:
//   0x00 CFG: b0 start (write-1 pulse, reads 0), b1 irq_en, b2 burst_en
//   0x08 SRC, 0x10 DST, 0x18 LEN: 32b RW
//   0x20 STAT: b0 active, b1 done (W1C), b2 error (W1C), b[4:3] dma_st_t
//   0x28 ERRADDR (RO), 0x30 ERRSRC b[1:0] err_src_t (RO)
//  Writes to undefined offsets, RO regs or outside the window: no effect.
//  Reset: all regs 0 except burst_en=BURST_EN_RST; state=DMA_ST_IDLE.
//   All outputs reset to 0: csr_resp_o, csr_rvalid_o, dma_go_o, irq_o, status.
//  FSM (dma_st_t):
//   IDLE -> RUN: CFG write with start=1 and LEN!=0; dma_go_o pulses the next cycle; desc is frozen.
//   IDLE, start with LEN==0: go to DONE directly; done=1; no go pulse.
//   RUN -> DONE: on dma_done_i, or on dma_error_i.valid; sets done, active=0.
//   DONE -> IDLE: write STAT with b1=1.
//   DONE + start: go to RUN and clear done (same rules as from IDLE).
//  While in RUN: writes to SRC/DST/LEN/start are ignored; irq_en/burst_en remain writable.
//  Error capture is sticky:
//   The first dma_error_i.valid while error==0 latches ERRADDR/ERRSRC and sets error.
//   Later errors are dropped until W1C of STAT b2.
//   If a W1C of error and a new error.valid occur in the same cycle, the set wins and the new error is latched.
//  A dma_done_i and an error in the same cycle: both are recorded; state -> DONE.
//  dma_done_i while IDLE/DONE: ignored.
//  Read path:
//   csr_rd_en -> csr_resp_o is loaded on the next edge with all slots (pre-write values if a write hits the same cycle).
//   csr_rvalid_o is high for that one cycle.
//   csr_resp_o holds its value otherwise. Slot n sits at bits [64n+31:64n].
//  A write and a read in the same cycle are both serviced.
//  Latency: register write to dma_desc_o/status visible is 1 cycle; CFG start to dma_go_o is 1 cycle.
//  Asynchronous reset mid-RUN: everything returns to reset values immediately.
//   No go/irq glitch after release. The DMA core is reset by the same rst_ni.
// STRUCTURE
//  dma_pkg gains:
//   csr_offset_e (0x00..0x30)
//   s_dma_cfg_t {burst_en, irq_en, start}
//   STAT bit-index localparams
//   CSR_SLOT_W=64
//  The existing VENUSDMA_*_OFFSET defines are reused.
//  Single module, with no sub-module. One optional helper function pack_csr_rdata() is placed in the package.
// TESTING
//  1. Reset, then read -> rvalid 1 cycle later, rdata=0 except CFG b2=`DMA_MAX_BURST_EN.
//  2. Write SRC=0x1000, DST=0x2000, LEN=0x40, CFG=0x3 -> go pulses 1 cycle, STAT=0x09 (RUN, active).
//     Then done_i -> STAT=0x12 (DONE, done), irq_o=1. W1C STAT=0x2 -> STAT=0x00, irq_o=0.
//  3. During RUN, write SRC=0xDEAD -> desc_o.src_addr stays 0x1000; a second CFG start gives no go pulse.
//  4. In RUN, error{valid,addr=0x2040,src=DMA_AXI_WR_ERR}, then error{0x3000,RD_ERR} ->
//     ERRADDR=0x2040, ERRSRC=1, STAT=0x16. W1C b2 in the same cycle as a new error -> error stays 1, new addr latched.
//  5. LEN=0, start -> no go pulse, STAT=0x12 the next cycle. Write to 0x38 or addr 0x1fff_0000 -> no register changes.
//  6. Assert rst_ni mid-RUN, then release -> all state back to reset values. A later start with LEN=0x80 works normally.

Source files
------------

// File: rtl/dma_csr_regfile_pkg.sv
// Shared types, register map and read-snapshot packing for the DMA CSR block.
package dma_csr_regfile_pkg;

  localparam logic [31:0] VENUSDMA_CTRLREG_OFFSET = 32'h1ffe_0000;
  localparam logic [5:0]  VENUSDMA_CFG_OFFSET     = 6'h00;
  localparam logic [5:0]  VENUSDMA_SRC_OFFSET     = 6'h08;
  localparam logic [5:0]  VENUSDMA_DST_OFFSET     = 6'h10;
  localparam logic [5:0]  VENUSDMA_LEN_OFFSET     = 6'h18;
  localparam logic [5:0]  VENUSDMA_STAT_OFFSET    = 6'h20;
  localparam logic [5:0]  VENUSDMA_ERRADDR_OFFSET = 6'h28;
  localparam logic [5:0]  VENUSDMA_ERRSRC_OFFSET  = 6'h30;

  localparam logic DMA_MAX_BURST_EN = 1'b1;

  localparam int unsigned CSR_SLOT_W = 64;
  localparam int unsigned CSR_WIN_W  = 8 * CSR_SLOT_W;

  localparam int unsigned STAT_ACTIVE_BIT = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;
  localparam int unsigned STAT_ERROR_BIT  = 2;
  localparam int unsigned STAT_ST_LSB     = 3;

  typedef enum logic [5:0] {
    CSR_CFG     = VENUSDMA_CFG_OFFSET,
    CSR_SRC     = VENUSDMA_SRC_OFFSET,
    CSR_DST     = VENUSDMA_DST_OFFSET,
    CSR_LEN     = VENUSDMA_LEN_OFFSET,
    CSR_STAT    = VENUSDMA_STAT_OFFSET,
    CSR_ERRADDR = VENUSDMA_ERRADDR_OFFSET,
    CSR_ERRSRC  = VENUSDMA_ERRSRC_OFFSET
  } csr_offset_e;

  typedef enum logic [1:0] {
    DMA_ST_IDLE = 2'd0,
    DMA_ST_RUN  = 2'd1,
    DMA_ST_DONE = 2'd2
  } dma_st_t;

  typedef enum logic [1:0] {
    DMA_NO_ERR     = 2'd0,
    DMA_AXI_WR_ERR = 2'd1,
    DMA_AXI_RD_ERR = 2'd2,
    DMA_STREAM_ERR = 2'd3
  } err_src_t;

  typedef struct packed {
    logic        wr_en;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd_en;
  } csr_req_t;

  typedef struct packed {
    logic [CSR_WIN_W-1:0] rdata;
  } csr_resp_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] num_bytes;
    logic [31:0] dst_addr;
  } s_dma_desc_t;

  typedef struct packed {
    logic        valid;
    err_src_t    src;
    logic [31:0] addr;
  } s_dma_error_t;

  typedef struct packed {
    logic error;
    logic done;
    logic active;
  } s_dma_status_t;

  typedef struct packed {
    logic burst_en;
    logic irq_en;
    logic start;
  } s_dma_cfg_t;

  // Whole-window snapshot; each slot carries 32 valid bits, upper half zero.
  function automatic logic [CSR_WIN_W-1:0] pack_csr_rdata(
    input s_dma_cfg_t    cfg,
    input s_dma_desc_t   desc,
    input s_dma_status_t st,
    input dma_st_t       fsm,
    input logic [31:0]   err_addr,
    input err_src_t      err_src
  );
    logic [CSR_WIN_W-1:0] r;
    r = '0;
    r[0*CSR_SLOT_W +: 32] = {29'd0, cfg.burst_en, cfg.irq_en, cfg.start};
    r[1*CSR_SLOT_W +: 32] = desc.src_addr;
    r[2*CSR_SLOT_W +: 32] = desc.dst_addr;
    r[3*CSR_SLOT_W +: 32] = desc.num_bytes;
    r[4*CSR_SLOT_W +: 32] = {27'd0, fsm, st.error, st.done, st.active};
    r[5*CSR_SLOT_W +: 32] = err_addr;
    r[6*CSR_SLOT_W +: 32] = {30'd0, err_src};
    return r;
  endfunction

endpackage

// File: rtl/dma_csr_regfile_if.sv
// CSR request/response bus between the SoC CSR bridge and the DMA register file.
interface dma_csr_regfile_if;
  import dma_csr_regfile_pkg::*;

  csr_req_t  req;
  csr_resp_t resp;
  logic      rvalid;

  modport master (output req, input resp, input rvalid);
  modport slave  (input req, output resp, output rvalid);
endinterface

// File: rtl/dma_csr_regfile.sv
// DMA CSR register file: descriptor/config/status registers, launch FSM,
// sticky error capture and interrupt generation.
module dma_csr_regfile
  import dma_csr_regfile_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = VENUSDMA_CTRLREG_OFFSET,
  parameter logic        BURST_EN_RST = DMA_MAX_BURST_EN
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dma_csr_regfile_if.slave     csr,
  output s_dma_desc_t          dma_desc_o,
  output logic                 dma_go_o,
  output logic                 burst_en_o,
  input  logic                 dma_done_i,
  input  s_dma_error_t         dma_error_i,
  output s_dma_status_t        dma_status_o,
  output logic                 irq_o
);

  dma_st_t              state_q, state_d;
  s_dma_cfg_t           cfg_q, cfg_d;
  s_dma_desc_t          desc_q, desc_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [31:0]          erraddr_q, erraddr_d;
  err_src_t             errsrc_q, errsrc_d;
  logic                 go_q, go_d;
  logic [CSR_WIN_W-1:0] resp_q, resp_d;
  logic                 rvalid_q, rvalid_d;

  logic          hit, running, start_req, w1c_done, w1c_err, run_end;
  logic          wr_cfg, wr_src, wr_dst, wr_len, wr_stat;
  logic [5:0]    off;
  logic [31:0]   wdata;
  s_dma_status_t status;

  // Write decode: window match, offset select and derived control events.
  always_comb begin
    hit       = csr.req.wr_en && (csr.req.waddr[31:6] == BASE_ADDR[31:6]);
    off       = csr.req.waddr[5:0];
    wdata     = csr.req.wdata;
    wr_cfg    = hit && (off == CSR_CFG);
    wr_src    = hit && (off == CSR_SRC);
    wr_dst    = hit && (off == CSR_DST);
    wr_len    = hit && (off == CSR_LEN);
    wr_stat   = hit && (off == CSR_STAT);
    running   = (state_q == DMA_ST_RUN);
    start_req = wr_cfg && wdata[0] && !running;
    w1c_done  = wr_stat && wdata[STAT_DONE_BIT];
    w1c_err   = wr_stat && wdata[STAT_ERROR_BIT];
    run_end   = running && (dma_done_i || dma_error_i.valid);
    status    = '{error: error_q, done: done_q, active: running};
  end

  // Launch FSM next-state and go pulse.
  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    unique case (state_q)
      DMA_ST_IDLE, DMA_ST_DONE: begin
        if (start_req) begin
          if (desc_q.num_bytes != 32'd0) begin
            state_d = DMA_ST_RUN;
            go_d    = 1'b1;
          end else begin
            state_d = DMA_ST_DONE;
          end
        end else if ((state_q == DMA_ST_DONE) && w1c_done) begin
          state_d = DMA_ST_IDLE;
        end
      end
      DMA_ST_RUN: begin
        if (run_end) state_d = DMA_ST_DONE;
      end
      default: state_d = DMA_ST_IDLE;
    endcase
  end

  // Register datapath: writes, W1C status, error capture and read snapshot.
  always_comb begin
    cfg_d     = cfg_q;
    desc_d    = desc_q;
    done_d    = done_q;
    error_d   = error_q;
    erraddr_d = erraddr_q;
    errsrc_d  = errsrc_q;
    resp_d    = resp_q;
    rvalid_d  = csr.req.rd_en;

    if (wr_cfg) begin
      cfg_d.irq_en   = wdata[1];
      cfg_d.burst_en = wdata[2];
    end
    cfg_d.start = 1'b0;

    if (!running) begin
      if (wr_src) desc_d.src_addr  = wdata;
      if (wr_dst) desc_d.dst_addr  = wdata;
      if (wr_len) desc_d.num_bytes = wdata;
    end

    // Clears are applied first so that hardware set events take priority.
    if (w1c_done)  done_d = 1'b0;
    if (start_req) done_d = (desc_q.num_bytes == 32'd0);
    if (run_end)   done_d = 1'b1;

    if (w1c_err) error_d = 1'b0;
    if (dma_error_i.valid && (!error_q || w1c_err)) begin
      error_d   = 1'b1;
      erraddr_d = dma_error_i.addr;
      errsrc_d  = dma_error_i.src;
    end

    if (csr.req.rd_en)
      resp_d = pack_csr_rdata(cfg_q, desc_q, status, state_q, erraddr_q, errsrc_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DMA_ST_IDLE;
      cfg_q     <= '{burst_en: BURST_EN_RST, irq_en: 1'b0, start: 1'b0};
      desc_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      erraddr_q <= '0;
      errsrc_q  <= DMA_NO_ERR;
      go_q      <= 1'b0;
      resp_q    <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      desc_q    <= desc_d;
      done_q    <= done_d;
      error_q   <= error_d;
      erraddr_q <= erraddr_d;
      errsrc_q  <= errsrc_d;
      go_q      <= go_d;
      resp_q    <= resp_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign csr.resp.rdata = resp_q;
  assign csr.rvalid     = rvalid_q;
  assign dma_desc_o     = desc_q;
  assign dma_go_o       = go_q;
  assign burst_en_o     = cfg_q.burst_en;
  assign dma_status_o   = status;
  assign irq_o          = cfg_q.irq_en & (done_q | error_q);

endmodule
